// File: rtl/pipeline_result_collector_pkg.sv
// Shared pipeline package: in_data field layout for permutation-pipeline bot words,
// collector state encoding and the packed per-top result metadata.
package pipeline_result_collector_pkg;

  localparam int SUMMED_LSB = 0;
  localparam int SUMMED_W   = 48;
  localparam int PCOEFF_LSB = 48;
  localparam int PCOEFF_W   = 13;
  localparam int ECC_BIT    = 63;
  localparam int ECC_W      = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } collector_state_t;

  typedef struct packed {
    logic [63:0]      occupancy;
    logic [ECC_W-1:0] ecc_errors;
    logic             overflow;
  } collector_result_t;

  // Saturating increment: the ECC counter sticks at all-ones instead of wrapping.
  function automatic logic [ECC_W-1:0] ecc_sat_inc(input logic [ECC_W-1:0] cnt, input logic hit);
    if (hit && (cnt != '1)) return cnt + ECC_W'(1);
    return cnt;
  endfunction

endpackage

// File: rtl/pipeline_result_collector.sv
// Collects bot results of the permutation pipeline into one per-top summary, emitted on the top word.
// Define COLLECTOR_ECC_COUNT_EN to count bot words with eccStatus set; otherwise out_ecc_errors is 0.
module pipeline_result_collector
  import pipeline_result_collector_pkg::*;
#(
  parameter int SUM_W = 64,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_top,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_pcoeff_total,
  output logic [CNT_W-1:0] out_bot_count,
  output logic [63:0]      out_occupancy,
  output logic [15:0]      out_ecc_errors,
  output logic             out_overflow
);

  collector_state_t  r_state;
  logic              r_out_valid;
  logic [SUM_W-1:0]  r_sum_acc;
  logic [CNT_W-1:0]  r_pc_acc;
  logic [CNT_W-1:0]  r_cnt_acc;
  logic              r_ovf_acc;
  logic [SUM_W-1:0]  r_out_sum;
  logic [CNT_W-1:0]  r_out_pcoeff;
  logic [CNT_W-1:0]  r_out_count;
  collector_result_t r_out_meta;

  logic                w_accept;
  logic                w_take_bot;
  logic                w_take_top;
  logic [SUMMED_W-1:0] w_summed;
  logic [PCOEFF_W-1:0] w_pcoeff;
  logic [SUM_W:0]      w_sum_add;
  logic [CNT_W:0]      w_pc_add;
  logic [CNT_W:0]      w_cnt_add;
  logic [ECC_W-1:0]    w_ecc_acc;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_take_bot = w_accept && !in_is_top;
  assign w_take_top = w_accept && in_is_top;

  assign w_summed  = in_data[SUMMED_LSB +: SUMMED_W];
  assign w_pcoeff  = in_data[PCOEFF_LSB +: PCOEFF_W];
  // One extra bit on each adder captures the carry that marks a wrap.
  assign w_sum_add = {1'b0, r_sum_acc} + (SUM_W+1)'(w_summed);
  assign w_pc_add  = {1'b0, r_pc_acc}  + (CNT_W+1)'(w_pcoeff);
  assign w_cnt_add = {1'b0, r_cnt_acc} + (CNT_W+1)'(1);

`ifdef COLLECTOR_ECC_COUNT_EN
  logic             w_ecc_bit;
  logic [ECC_W-1:0] r_ecc_acc;

  assign w_ecc_bit = in_data[ECC_BIT];
  assign w_ecc_acc = r_ecc_acc;

  always_ff @(posedge clock) begin
    if (!rst || w_take_top) begin
      r_ecc_acc <= '0;
    end else if (w_take_bot) begin
      r_ecc_acc <= ecc_sat_inc(r_ecc_acc, w_ecc_bit);
    end
  end
`else
  assign w_ecc_acc = '0;
`endif

  always_ff @(posedge clock) begin
    if (!rst) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_sum_acc    <= '0;
      r_pc_acc     <= '0;
      r_cnt_acc    <= '0;
      r_ovf_acc    <= 1'b0;
      r_out_sum    <= '0;
      r_out_pcoeff <= '0;
      r_out_count  <= '0;
      r_out_meta   <= '0;
    end else if (w_take_top) begin
      // A top word in HOLD with out_ready replaces the held result with no bubble.
      r_state      <= ST_HOLD;
      r_out_valid  <= 1'b1;
      r_out_sum    <= r_sum_acc;
      r_out_pcoeff <= r_pc_acc;
      r_out_count  <= r_cnt_acc;
      r_out_meta   <= '{occupancy: in_data, ecc_errors: w_ecc_acc, overflow: r_ovf_acc};
      r_sum_acc    <= '0;
      r_pc_acc     <= '0;
      r_cnt_acc    <= '0;
      r_ovf_acc    <= 1'b0;
    end else begin
      if (w_take_bot) begin
        r_sum_acc <= w_sum_add[SUM_W-1:0];
        r_pc_acc  <= w_pc_add[CNT_W-1:0];
        r_cnt_acc <= w_cnt_add[CNT_W-1:0];
        r_ovf_acc <= r_ovf_acc | w_sum_add[SUM_W] | w_pc_add[CNT_W] | w_cnt_add[CNT_W];
      end
      case (r_state)
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= w_take_bot ? ST_ACCUM : ST_EMPTY;
          end
        end
        default: begin
          if (w_take_bot) r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  assign out_valid        = r_out_valid;
  assign out_sum          = r_out_sum;
  assign out_pcoeff_total = r_out_pcoeff;
  assign out_bot_count    = r_out_count;
  assign out_occupancy    = r_out_meta.occupancy;
  assign out_ecc_errors   = r_out_meta.ecc_errors;
  assign out_overflow     = r_out_meta.overflow;

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Bench for pipeline_result_collector: directed scenarios then random traffic, checked every cycle
// against a totals-based reference model (default 64-bit instance plus a SUM_W=48 instance).
module tb_pipeline_result_collector;

`ifdef COLLECTOR_ECC_COUNT_EN
  localparam bit ECC_ON = 1'b1;
`else
  localparam bit ECC_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_is_top;
  logic [63:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid, out_overflow;
  logic [63:0] out_sum, out_occupancy;
  logic [31:0] out_pcoeff_total, out_bot_count;
  logic [15:0] out_ecc_errors;

  logic        w48_in_ready, w48_out_valid, w48_out_overflow;
  logic [47:0] w48_out_sum;
  logic [63:0] w48_out_occupancy;
  logic [31:0] w48_out_pcoeff_total, w48_out_bot_count;
  logic [15:0] w48_out_ecc_errors;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: held result plus exact (unwrapped) running totals since the last top.
  bit          m_held;
  logic [63:0] m_sum64, m_occ;
  logic [47:0] m_sum48;
  logic [31:0] m_pc, m_cnt;
  logic [15:0] m_ecc;
  bit          m_ovf64, m_ovf48;
  logic [79:0] a_sum;
  logic [63:0] a_pc;
  int unsigned a_cnt, a_ecc;

  always #5 clock = ~clock;

  pipeline_result_collector dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_top(in_is_top), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_pcoeff_total(out_pcoeff_total), .out_bot_count(out_bot_count),
    .out_occupancy(out_occupancy), .out_ecc_errors(out_ecc_errors), .out_overflow(out_overflow)
  );

  pipeline_result_collector #(.SUM_W(48), .CNT_W(32)) dut48 (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(w48_in_ready), .in_is_top(in_is_top), .in_data(in_data),
    .out_valid(w48_out_valid), .out_ready(out_ready),
    .out_sum(w48_out_sum), .out_pcoeff_total(w48_out_pcoeff_total), .out_bot_count(w48_out_bot_count),
    .out_occupancy(w48_out_occupancy), .out_ecc_errors(w48_out_ecc_errors), .out_overflow(w48_out_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_sum64 = '0; m_sum48 = '0; m_pc = '0; m_cnt = '0; m_occ = '0;
    m_ecc = '0; m_ovf64 = 0; m_ovf48 = 0;
    a_sum = '0; a_pc = '0; a_cnt = 0; a_ecc = 0;
  endtask

  function automatic logic [63:0] mk_bot(input logic [47:0] s, input logic [12:0] p, input logic e);
    return {e, 2'b00, p, s};
  endfunction

  task automatic compare_all();
    bit exp_ready;
    exp_ready = !m_held || out_ready;
    check("in_ready",      64'(in_ready),          64'(exp_ready));
    check("out_valid",     64'(out_valid),         64'(m_held));
    check("out_sum",       out_sum,                m_sum64);
    check("out_pcoeff",    64'(out_pcoeff_total),  64'(m_pc));
    check("out_count",     64'(out_bot_count),     64'(m_cnt));
    check("out_occ",       out_occupancy,          m_occ);
    check("out_ecc",       64'(out_ecc_errors),    64'(m_ecc));
    check("out_ovf",       64'(out_overflow),      64'(m_ovf64));
    check("w48_in_ready",  64'(w48_in_ready),      64'(exp_ready));
    check("w48_out_valid", 64'(w48_out_valid),     64'(m_held));
    check("w48_out_sum",   64'(w48_out_sum),       64'(m_sum48));
    check("w48_out_ovf",   64'(w48_out_overflow),  64'(m_ovf48));
  endtask

  // One clock: drive at the falling edge, compare just after, then advance the model
  // to what the upcoming rising edge should produce.
  task automatic cycle(input bit r, input bit v, input bit top, input logic [63:0] d, input bit ordy);
    bit acc;
    @(negedge clock);
    rst = r; in_valid = v; in_is_top = top; in_data = d; out_ready = ordy;
    #1;
    compare_all();
    if (!r) begin
      model_reset();
    end else begin
      acc = v && (!m_held || ordy);
      if (acc && top) begin
        m_held  = 1;
        m_sum64 = a_sum[63:0];
        m_sum48 = a_sum[47:0];
        m_pc    = a_pc[31:0];
        m_cnt   = a_cnt;
        m_occ   = d;
        m_ecc   = !ECC_ON ? 16'h0 : (a_ecc > 65535 ? 16'hFFFF : 16'(a_ecc));
        m_ovf64 = (a_sum[79:64] != 0) || (a_pc[63:32] != 0);
        m_ovf48 = (a_sum[79:48] != 0) || (a_pc[63:32] != 0);
        a_sum = '0; a_pc = '0; a_cnt = 0; a_ecc = 0;
      end else begin
        if (acc) begin
          a_sum = a_sum + 80'(d[47:0]);
          a_pc  = a_pc + 64'(d[60:48]);
          a_cnt = a_cnt + 1;
          a_ecc = a_ecc + 32'(d[63]);
        end
        if (m_held && ordy) m_held = 0;
      end
    end
  endtask

  initial begin
    logic [63:0] d;
    rst = 0; in_valid = 0; in_is_top = 0; in_data = '0; out_ready = 0;
    model_reset();
    repeat (3) @(posedge clock);

    // Reset state, then a top straight after reset gives an all-zero result.
    cycle(1, 0, 0, 64'h0, 0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    cycle(1, 1, 1, 64'h1234, 0);
    cycle(1, 0, 0, 64'h0, 0);
    check("r34_valid", 64'(out_valid), 64'd1);
    check("r34_count", 64'(out_bot_count), 64'd0);
    check("r34_sum", out_sum, 64'd0);
    cycle(1, 0, 0, 64'h0, 1);

    // Three bots then top 0xABCD, held with out_ready low.
    cycle(1, 1, 0, mk_bot(48'd10, 13'd1, 1'b0), 1);
    cycle(1, 1, 0, mk_bot(48'd20, 13'd2, 1'b0), 1);
    cycle(1, 1, 0, mk_bot(48'd30, 13'd3, 1'b0), 1);
    cycle(1, 1, 1, 64'hABCD, 0);
    cycle(1, 0, 0, 64'h0, 0);
    check("r33_valid", 64'(out_valid), 64'd1);
    check("r33_sum", out_sum, 64'd60);
    check("r33_pcoeff", 64'(out_pcoeff_total), 64'd6);
    check("r33_count", 64'(out_bot_count), 64'd3);
    check("r33_occ", out_occupancy, 64'hABCD);

    // Stall for 5 cycles with a bot offered; then two bots accumulate from zero.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, mk_bot(48'd99, 13'd9, 1'b0), 0);
      check("r35_stall", 64'(in_ready), 64'd0);
      check("r35_stable", out_sum, 64'd60);
    end
    cycle(1, 1, 0, mk_bot(48'd5, 13'd1, 1'b0), 1);
    cycle(1, 1, 0, mk_bot(48'd7, 13'd2, 1'b0), 1);
    cycle(1, 1, 1, 64'h77, 0);
    cycle(1, 0, 0, 64'h0, 0);
    check("r35_count", 64'(out_bot_count), 64'd2);
    check("r35_sum", out_sum, 64'd12);

    // Back-to-back tops with out_ready high.
    cycle(1, 1, 1, 64'h1111, 1);
    cycle(1, 1, 1, 64'h2222, 1);
    check("r36_valid_a", 64'(out_valid), 64'd1);
    check("r36_occ_a", out_occupancy, 64'h1111);
    cycle(1, 0, 0, 64'h0, 1);
    check("r36_valid_b", 64'(out_valid), 64'd1);
    check("r36_occ_b", out_occupancy, 64'h2222);

    // 48-bit wrap on the narrow instance, then a clean top.
    cycle(1, 1, 0, mk_bot(48'hFFFF_FFFF_FFFF, 13'd0, 1'b0), 1);
    cycle(1, 1, 0, mk_bot(48'hFFFF_FFFF_FFFF, 13'd0, 1'b0), 1);
    cycle(1, 1, 1, 64'h4848, 1);
    cycle(1, 0, 0, 64'h0, 0);
    check("r37_sum48", 64'(w48_out_sum), 64'h0000_FFFF_FFFF_FFFE);
    check("r37_ovf48", 64'(w48_out_overflow), 64'd1);
    check("r37_ovf64", 64'(out_overflow), 64'd0);
    cycle(1, 1, 0, mk_bot(48'd3, 13'd0, 1'b0), 1);
    cycle(1, 1, 1, 64'h4849, 1);
    cycle(1, 0, 0, 64'h0, 0);
    check("r37_clean", 64'(w48_out_overflow), 64'd0);

    // ECC counting on 2 of 4 bots.
    cycle(1, 1, 0, mk_bot(48'd1, 13'd0, 1'b1), 1);
    cycle(1, 1, 0, mk_bot(48'd1, 13'd0, 1'b0), 1);
    cycle(1, 1, 0, mk_bot(48'd1, 13'd0, 1'b1), 1);
    cycle(1, 1, 0, mk_bot(48'd1, 13'd0, 1'b0), 1);
    cycle(1, 1, 1, 64'hECC0, 1);
    cycle(1, 0, 0, 64'h0, 1);
    check("r38_ecc", 64'(out_ecc_errors), ECC_ON ? 64'd2 : 64'd0);

    // Reset mid-accumulation discards earlier bots.
    cycle(1, 1, 0, mk_bot(48'd100, 13'd1, 1'b0), 1);
    cycle(1, 1, 0, mk_bot(48'd100, 13'd1, 1'b0), 1);
    cycle(0, 0, 0, 64'h0, 1);
    cycle(1, 1, 0, mk_bot(48'd4, 13'd1, 1'b0), 1);
    check("r28_ready", 64'(in_ready), 64'd1);
    cycle(1, 1, 0, mk_bot(48'd6, 13'd1, 1'b0), 1);
    cycle(1, 1, 1, 64'h5EED, 0);
    cycle(1, 0, 0, 64'h0, 0);
    check("r38_rst_count", 64'(out_bot_count), 64'd2);
    check("r38_rst_sum", out_sum, 64'd10);

    // Random traffic with occasional resets and near-full summedData values.
    for (int i = 0; i < 3000; i++) begin
      d = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) d[47:0] = 48'hFFFF_FFFF_FF00 | 48'($urandom_range(0, 255));
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0, d, $urandom_range(0, 2) != 0);
    end
    cycle(1, 0, 0, 64'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
